card_dealer: RTL
================

// Module: card_dealer
// PURPOSE
//  Upstream card source for the bell game. Deals one card per player (colour c1/c2, number n1/n2)
//  every round, tracks pile size as count, and restarts the pile when the scoring stage
//  reports a bell press via finish.
//  Drives is_right (cards) and score_control (count); consumes score_control.finish.
// PARAMETERS
//  SEED         16'hACE1  LFSR reset value; 0 is replaced by 16'hACE1
//  DEAL_PERIOD  8'd50     cycles the card pair is shown before the next deal (1..255)
//  DECK_SIZE    8'd56     total cards per game; used only with DEAL_LIMIT_EN
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst         in   1  synchronous reset, active-low
//  start       in   1  begins dealing; sampled only in IDLE
//  finish      in   1  from score_control; 1 = bell resolved, clear pile
//  c1, c2      out  2  card colour, player A / B (0..3)
//  n1, n2      out  3  card number, player A / B (1..5 while dealt, 0 when cleared)
//  count       out  8  cards on pile, unsigned, saturates at 8'hFF
//  new_pair    out  1  1-cycle pulse: fresh c1/n1/c2/n2 pair valid
//  deck_empty  out  1  game over (DEAL_LIMIT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=0 at edge): state=IDLE, lfsr=SEED, c1=c2=n1=n2=0, count=0, new_pair=0,
//    deck_empty=0, timer=0. Reset mid-round aborts the round immediately.
//  - LFSR: 16-bit Galois, mask 16'hB400, advances every non-reset cycle in every state.
//    Card map: number = (lfsr[7:0] % 5) + 1, colour = lfsr[9:8].
//  - States: IDLE, DEAL_A, DEAL_B, SHOW, HOLD, DONE.
//    IDLE: start=1 -> DEAL_A; outputs held.
//    DEAL_A: c1/n1 <= map(lfsr); count += 1 (sat) -> DEAL_B.
//    DEAL_B: c2/n2 <= map(lfsr); count += 1 (sat); new_pair <= 1; timer <= 0 -> SHOW.
//    SHOW: timer increments; when timer == DEAL_PERIOD-1 -> DEAL_A. Pair held stable.
//    HOLD: waits while finish=1; finish=0 -> DEAL_A.
//    DONE: terminal until reset (DEAL_LIMIT_EN only).
//  - Latency: start sampled at edge k -> count=1 at k+1, count=2 and new_pair=1 at k+2;
//    next new_pair at k+4+DEAL_PERIOD (round period = DEAL_PERIOD+2 cycles).
//  - new_pair is 0 on every edge except the one leaving DEAL_B.
//  - finish=1 sampled in DEAL_A/DEAL_B/SHOW/HOLD: count<=0, c1=c2=n1=n2<=0, new_pair<=0,
//    timer<=0, state<=HOLD. finish has priority over the timer and over dealing in the
//    same cycle. finish ignored in IDLE and DONE.
//  - Count saturation: at 8'hFF further deals leave count at 8'hFF; no wrap.
//  - Colours/numbers are never 0-number while a pair is shown (n in 1..5).
// CONFIGURATION
//  DEAL_LIMIT_EN defined: in SHOW at timer == DEAL_PERIOD-1, if count >= DECK_SIZE ->
//    DONE with deck_empty <= 1 (held until reset); cards and count frozen; start and
//    finish ignored. finish in the same cycle still wins (-> HOLD, count 0).
//  DEAL_LIMIT_EN undefined: no DONE state, deck_empty constant 0, dealing unbounded.
// TESTING (bench uses DEAL_PERIOD=4, DECK_SIZE=6)
//  1 rst=0 two cycles, release -> all outputs 0, state IDLE; start=0 for 10 cycles -> count stays 0.
//  2 start pulse at edge k -> count 1 @k+1, 2 @k+2 with new_pair=1; new_pair again @k+8, count=4.
//  3 1000 rounds -> every n1,n2 in 1..5, c1,c2 in 0..3, new_pair exactly one cycle wide.
//  4 finish=1 for 2 cycles during SHOW -> count=0, n1=n2=0, no new_pair; finish drops ->
//    count=1 next edge, new pair one edge later.
//  5 finish=1 on the SHOW-exit edge -> HOLD, not DEAL_A; count=0.
//  6 DEAL_LIMIT_EN: after third pair (count=6) and 4 SHOW cycles -> deck_empty=1, count held 6;
//    start/finish pulses -> no change; rst=0 -> deck_empty=0. Without macro: count reaches 8.

Source files
------------

// File: rtl/card_dealer.sv
// Card source for the bell game: deals one card per player each round and tracks the pile size.
// Optional DEAL_LIMIT_EN adds a deck limit with a terminal DONE state and deck_empty flag.
module card_dealer #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [7:0]  DEAL_PERIOD = 8'd50,
  parameter logic [7:0]  DECK_SIZE   = 8'd56
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       finish,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       new_pair,
  output logic       deck_empty
);
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned NUM_W   = 3;
  localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
  localparam logic [CNT_W-1:0]  LAST_TICK = DEAL_PERIOD - 8'd1;

`ifdef DEAL_LIMIT_EN
  typedef enum logic [2:0] {IDLE, DEAL_A, DEAL_B, SHOW, HOLD, DONE} state_t;
  logic empty_d;
`else
  typedef enum logic [2:0] {IDLE, DEAL_A, DEAL_B, SHOW, HOLD} state_t;
  logic unused_deck_size;
  assign unused_deck_size = ^DECK_SIZE;
  assign deck_empty       = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  count_d, count_inc;
  logic [1:0]        c1_d, c2_d, card_c;
  logic [NUM_W-1:0]  n1_d, n2_d, card_n;
  logic              new_pair_d;

  // Card drawn from the current LFSR value; number lands in 1..5
  assign card_c    = lfsr_q[9:8];
  assign card_n    = NUM_W'(lfsr_q[7:0] % 8'd5) + 3'd1;
  assign count_inc = (count == 8'hFF) ? count : count + 8'd1;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
    timer_d    = timer_q;
    count_d    = count;
    c1_d       = c1;
    c2_d       = c2;
    n1_d       = n1;
    n2_d       = n2;
    new_pair_d = 1'b0;
`ifdef DEAL_LIMIT_EN
    empty_d    = deck_empty;
`endif
    case (state_q)
      IDLE: if (start) state_d = DEAL_A;
      DEAL_A: begin
        c1_d    = card_c;
        n1_d    = card_n;
        count_d = count_inc;
        state_d = DEAL_B;
      end
      DEAL_B: begin
        c2_d       = card_c;
        n2_d       = card_n;
        count_d    = count_inc;
        new_pair_d = 1'b1;
        timer_d    = '0;
        state_d    = SHOW;
      end
      SHOW: begin
        if (timer_q == LAST_TICK) begin
`ifdef DEAL_LIMIT_EN
          if (count >= DECK_SIZE) begin
            state_d = DONE;
            empty_d = 1'b1;
          end else begin
            state_d = DEAL_A;
          end
`else
          state_d = DEAL_A;
`endif
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      HOLD: if (!finish) state_d = DEAL_A;
`ifdef DEAL_LIMIT_EN
      DONE: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
    // Bell press clears the pile and overrides dealing and the show timer
    if (finish && (state_q == DEAL_A || state_q == DEAL_B ||
                   state_q == SHOW || state_q == HOLD)) begin
      count_d    = '0;
      c1_d       = '0;
      c2_d       = '0;
      n1_d       = '0;
      n2_d       = '0;
      new_pair_d = 1'b0;
      timer_d    = '0;
      state_d    = HOLD;
`ifdef DEAL_LIMIT_EN
      empty_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      timer_q  <= '0;
      count    <= '0;
      c1       <= '0;
      c2       <= '0;
      n1       <= '0;
      n2       <= '0;
      new_pair <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      count    <= count_d;
      c1       <= c1_d;
      c2       <= c2_d;
      n1       <= n1_d;
      n2       <= n2_d;
      new_pair <= new_pair_d;
    end
  end

`ifdef DEAL_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!rst) deck_empty <= 1'b0;
    else      deck_empty <= empty_d;
  end
`endif

endmodule
